// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button request controller.
// Synchronizes and debounces a raw button and turns presses into pass grants.
// It enforces a lockout window after each grant, and can queue one request
// that arrives during that window.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   btn_raw      asynchronous bouncy button, high = pressed
//   light_g      downstream green lamp (synchronous to clk)
//   pass         registered grant pulse, PASS_CYCLES wide
//   req_pending  registered; a request is waiting for a grant
//   lockout      registered; post-grant lockout window active
//   pass_count   registered count of grants issued (wraps at 256)

module ped_request_ctrl #(
    parameter int DEB_CYCLES     = 16,
    parameter int PASS_CYCLES    = 1,
    parameter int LOCKOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       light_g,
    output logic       pass,
    output logic       req_pending,
    output logic       lockout,
    output logic [7:0] pass_count
);

    localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [3:0]  PASS_LAST = 4'(PASS_CYCLES - 1);
    localparam logic [11:0] LOCK_LAST = 12'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_ISSUE,
        S_LOCKOUT
    } state_t;

    // Synchronizer
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic btn_s;

    // Debouncer
    logic       btn_db_q, btn_db_d;
    logic       btn_db_prev_q, btn_db_prev_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       press_evt;

    // Request FSM
    state_t      state_q, state_d;
    logic        queued_q, queued_d;
    logic [3:0]  pass_cnt_q, pass_cnt_d;
    logic [11:0] lock_cnt_q, lock_cnt_d;
    logic [7:0]  pass_count_q, pass_count_d;

    // Registered outputs
    logic pass_q, pass_d;
    logic req_pending_q, req_pending_d;
    logic lockout_q, lockout_d;

    // ------------------------------------------------------------------
    // Two-flop synchronizer: the only consumer of btn_raw.
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    assign btn_s = sync2_q;

    // ------------------------------------------------------------------
    // Debounce: accept a new level only after it has differed from the
    // accepted level for DEB_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    always_comb begin
        btn_db_d      = btn_db_q;
        db_cnt_d      = '0;
        btn_db_prev_d = btn_db_q;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DEB_LAST) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    // Only presses count; releases are deliberately silent.
    assign press_evt = btn_db_q & ~btn_db_prev_q;

    // ------------------------------------------------------------------
    // Request FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        queued_d     = queued_q;
        pass_cnt_d   = pass_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        pass_count_d = pass_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (press_evt) begin
                    state_d = S_PENDING;
                end
            end

            S_PENDING: begin
                // A green lamp already serves the pedestrian, so the
                // request is absorbed without a grant.
                if (light_g) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_ISSUE;
                    pass_cnt_d   = '0;
                    pass_count_d = pass_count_q + 8'd1;
                end
            end

            S_ISSUE: begin
                if (pass_cnt_q == PASS_LAST) begin
                    state_d    = S_LOCKOUT;
                    lock_cnt_d = '0;
                end else begin
                    pass_cnt_d = pass_cnt_q + 4'd1;
                end
            end

            S_LOCKOUT: begin
                if (press_evt) begin
                    queued_d = 1'b1;
                end
                if (lock_cnt_q == LOCK_LAST) begin
                    // A press on the final lockout cycle still queues.
                    if (queued_q | press_evt) begin
                        state_d = S_PENDING;
                    end else begin
                        state_d = S_IDLE;
                    end
                    queued_d = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 12'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        pass_d        = (state_d == S_ISSUE);
        req_pending_d = (state_d == S_PENDING) | queued_d;
        lockout_d     = (state_d == S_LOCKOUT);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= S_IDLE;
            queued_q      <= 1'b0;
            pass_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            pass_count_q  <= '0;
            pass_q        <= 1'b0;
            req_pending_q <= 1'b0;
            lockout_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_prev_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            queued_q      <= queued_d;
            pass_cnt_q    <= pass_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            pass_count_q  <= pass_count_d;
            pass_q        <= pass_d;
            req_pending_q <= req_pending_d;
            lockout_q     <= lockout_d;
        end
    end

    assign pass        = pass_q;
    assign req_pending = req_pending_q;
    assign lockout     = lockout_q;
    assign pass_count  = pass_count_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: two instances (default and small parameters)
// checked every cycle against a countdown-based reference model.

module tb_ped_request_ctrl;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] btn;
    logic [1:0] lg;
    logic [1:0] pass_o;
    logic [1:0] reqp_o;
    logic [1:0] lock_o;
    logic [7:0] cnt_o [2];

    ped_request_ctrl u_dut0 (
        .clk         (clk),
        .rst         (rst[0]),
        .btn_raw     (btn[0]),
        .light_g     (lg[0]),
        .pass        (pass_o[0]),
        .req_pending (reqp_o[0]),
        .lockout     (lock_o[0]),
        .pass_count  (cnt_o[0])
    );

    ped_request_ctrl #(
        .DEB_CYCLES     (4),
        .PASS_CYCLES    (3),
        .LOCKOUT_CYCLES (1)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst[1]),
        .btn_raw     (btn[1]),
        .light_g     (lg[1]),
        .pass        (pass_o[1]),
        .req_pending (reqp_o[1]),
        .lockout     (lock_o[1]),
        .pass_count  (cnt_o[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int p_deb(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic int p_pass(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int p_lock(input int k);
        return (k == 0) ? 2048 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: the controller is described by how many pass and
    // lockout cycles remain, plus pending/queued request bits.
    int m_s1 [2], m_s2 [2], m_db [2], m_dbp [2], m_dc [2];
    int m_pend [2], m_issue [2], m_lock [2], m_q [2], m_cnt [2];
    bit m_valid [2];

    task automatic model_step(input int k);
        bit press;
        if (rst[k]) begin
            m_s1[k] = 0; m_s2[k] = 0; m_db[k] = 0; m_dbp[k] = 0;
            m_dc[k] = 0; m_pend[k] = 0; m_issue[k] = 0;
            m_lock[k] = 0; m_q[k] = 0; m_cnt[k] = 0;
            m_valid[k] = 1'b1;
        end else begin
            press = (m_db[k] == 1) && (m_dbp[k] == 0);
            m_dbp[k] = m_db[k];
            if (m_s2[k] != m_db[k]) begin
                if (m_dc[k] == p_deb(k) - 1) begin
                    m_db[k] = m_s2[k];
                    m_dc[k] = 0;
                end else begin
                    m_dc[k] = m_dc[k] + 1;
                end
            end else begin
                m_dc[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = int'(btn[k]);
            if (m_pend[k] != 0) begin
                m_pend[k] = 0;
                if (!lg[k]) begin
                    m_issue[k] = p_pass(k);
                    m_cnt[k] = (m_cnt[k] + 1) % 256;
                end
            end else if (m_issue[k] > 0) begin
                m_issue[k] = m_issue[k] - 1;
                if (m_issue[k] == 0) m_lock[k] = p_lock(k);
            end else if (m_lock[k] > 0) begin
                if (press) m_q[k] = 1;
                m_lock[k] = m_lock[k] - 1;
                if (m_lock[k] == 0) begin
                    m_pend[k] = m_q[k];
                    m_q[k] = 0;
                end
            end else if (press) begin
                m_pend[k] = 1;
            end
        end
    endtask

    initial begin
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k]) begin
                    chk($sformatf("u%0d_pass", k), int'(pass_o[k]),
                        int'(m_issue[k] > 0));
                    chk($sformatf("u%0d_req_pending", k), int'(reqp_o[k]),
                        int'(m_pend[k] != 0 || m_q[k] != 0));
                    chk($sformatf("u%0d_lockout", k), int'(lock_o[k]),
                        int'(m_lock[k] > 0));
                    chk($sformatf("u%0d_pass_count", k), int'(cnt_o[k]),
                        m_cnt[k]);
                end
            end
        end
    end

    int  pass_hi;
    int  pass_rise;
    int  req_hi;
    bit  prevp;

    task automatic clr();
        pass_hi = 0;
        pass_rise = 0;
        req_hi = 0;
        prevp = 1'b0;
    endtask

    task automatic run(input int n, input int k);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (pass_o[k]) pass_hi++;
            if (pass_o[k] && !prevp) pass_rise++;
            prevp = pass_o[k];
            if (reqp_o[k]) req_hi++;
        end
    endtask

    initial begin
        int lk;
        int w;
        int wd;
        rst = 2'b11;
        btn = 2'b00;
        lg  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;

        // Clean press with defaults: exact grant timing and lockout width.
        btn[0] = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 17) chk("lat_no_pend_e17", int'(reqp_o[0]), 0);
            if (e == 18) chk("lat_pend_e18", int'(reqp_o[0]), 1);
            if (e == 18) chk("lat_nopass_e18", int'(pass_o[0]), 0);
            if (e == 19) chk("lat_pass_e19", int'(pass_o[0]), 1);
            if (e == 19) chk("lat_count_e19", int'(cnt_o[0]), 1);
            if (e == 20) chk("lat_pass_off_e20", int'(pass_o[0]), 0);
            if (e == 20) chk("lat_lock_e20", int'(lock_o[0]), 1);
        end
        lk = 1;
        while (lock_o[0] && lk < 3000) begin
            @(posedge clk);
            #1;
            if (lock_o[0]) lk++;
        end
        chk("lockout_width", lk, 2048);
        chk("idle_after_lock_req", int'(reqp_o[0]), 0);
        btn[0] = 1'b0;
        run(40, 0);

        // Bouncy pulses too short to debounce.
        clr();
        for (int r = 0; r < 5; r++) begin
            btn[0] = 1'b1;
            run(10, 0);
            btn[0] = 1'b0;
            run(3, 0);
        end
        run(40, 0);
        chk("bounce_pass_hi", pass_hi, 0);
        chk("bounce_req_hi", req_hi, 0);
        chk("bounce_count", int'(cnt_o[0]), 1);

        // Press while green: request absorbed.
        clr();
        lg[0] = 1'b1;
        btn[0] = 1'b1;
        run(30, 0);
        btn[0] = 1'b0;
        run(30, 0);
        lg[0] = 1'b0;
        chk("green_req_cycles", req_hi, 1);
        chk("green_pass_hi", pass_hi, 0);
        chk("green_count", int'(cnt_o[0]), 1);

        // Grant, then three presses during lockout -> one queued grant.
        clr();
        btn[0] = 1'b1;
        run(25, 0);
        btn[0] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            btn[0] = 1'b1;
            run(20, 0);
            btn[0] = 1'b0;
            run(20, 0);
        end
        chk("queued_req_pending", int'(reqp_o[0]), 1);
        run(2100, 0);
        chk("queued_grants", pass_rise, 2);
        chk("queued_pass_cycles", pass_hi, 2);
        chk("queued_count", int'(cnt_o[0]), 3);
        run(2100, 0);
        chk("queued_done_lock", int'(lock_o[0]), 0);

        // Random traffic on the default instance.
        for (int s = 0; s < 400; s++) begin
            btn[0] = 1'($urandom_range(0, 1));
            lg[0]  = ($urandom_range(0, 3) == 0);
            run($urandom_range(1, 40), 0);
        end
        btn[0] = 1'b0;

        // Reset during the second pass cycle (PASS_CYCLES=3).
        btn[1] = 1'b1;
        w = 0;
        while (!pass_o[1] && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("rst_first_pass", int'(pass_o[1]), 1);
        chk("rst_first_count", int'(cnt_o[1]), 1);
        @(posedge clk);
        #1;
        chk("rst_second_pass", int'(pass_o[1]), 1);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        chk("rst_pass", int'(pass_o[1]), 0);
        chk("rst_req", int'(reqp_o[1]), 0);
        chk("rst_lock", int'(lock_o[1]), 0);
        chk("rst_count", int'(cnt_o[1]), 0);
        clr();
        run(40, 1);
        chk("rst_held_regrant", pass_rise, 1);
        chk("rst_held_count", int'(cnt_o[1]), 1);
        btn[1] = 1'b0;
        run(20, 1);

        // 256 grants wrap the counter; every pass is 3 cycles wide.
        rst[1] = 1'b1;
        run(2, 1);
        rst[1] = 1'b0;
        for (int g = 0; g < 256; g++) begin
            btn[1] = 1'b1;
            w = 0;
            while (!pass_o[1] && w < 40) begin
                @(posedge clk);
                #1;
                w++;
            end
            wd = int'(pass_o[1]);
            while (pass_o[1] && wd < 20) begin
                @(posedge clk);
                #1;
                if (pass_o[1]) wd++;
            end
            chk($sformatf("wrap_width_%0d", g), wd, 3);
            btn[1] = 1'b0;
            run(10, 1);
        end
        chk("wrap_count", int'(cnt_o[1]), 0);

        // Random traffic on the small instance.
        for (int s = 0; s < 300; s++) begin
            btn[1] = 1'($urandom_range(0, 1));
            lg[1]  = ($urandom_range(0, 3) == 0);
            run($urandom_range(1, 15), 1);
        end
        btn[1] = 1'b0;
        run(5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ped_request_ctrl.md
PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16, SHALL set the consecutive synchronized-button cycles needed to accept a level change (legal 2..255).
REQ-002 Parameter PASS_CYCLES, default 1, SHALL set the cycles pass is held high per grant (legal 1..15).
REQ-003 Parameter LOCKOUT_CYCLES, default 2048, SHALL set the cycles after a grant during which no new grant is issued (legal 1..4095).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 btn_raw  in  1  asynchronous, bouncy pedestrian push-button, high = pressed.
REQ-007 light_g  in  1  green lamp from the downstream traffic-light controller, synchronous to clk.
REQ-008 pass  out  1  registered grant to the traffic-light controller's pass input.
REQ-009 req_pending  out  1  registered; high while a request awaits a grant (PENDING state or queued flag set).
REQ-010 lockout  out  1  registered; high while in LOCKOUT.
REQ-011 pass_count  out  8  registered count of grants issued.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer producing btn_s; no other logic SHALL sample btn_raw.
REQ-013 Debounce: 8-bit db_cnt SHALL increment each edge btn_s != btn_db and clear each edge btn_s == btn_db; when btn_s != btn_db and db_cnt == DEB_CYCLES-1, btn_db SHALL take btn_s and db_cnt SHALL clear.
REQ-014 press_evt SHALL be btn_db rising (btn_db & ~btn_db_prev); falling edges SHALL produce no event.
REQ-015 FSM states SHALL be IDLE, PENDING, ISSUE, LOCKOUT; plus 1-bit flag queued.
REQ-016 IDLE: press_evt -> PENDING; else stay.
REQ-017 PENDING: light_g==1 -> IDLE (request absorbed, no grant, pass_count unchanged); light_g==0 -> ISSUE.
REQ-018 ISSUE: pass SHALL be 1 for exactly PASS_CYCLES cycles, then -> LOCKOUT; pass_count SHALL increment once per grant on ISSUE entry, wrapping 255 -> 0.
REQ-019 LOCKOUT: 12-bit lock_cnt loaded 0 on entry, increments each cycle; after LOCKOUT_CYCLES cycles -> PENDING if queued, else IDLE; queued clears on exit.
REQ-020 press_evt during PENDING or ISSUE SHALL be ignored; press_evt during LOCKOUT SHALL set queued (multiple presses = one queued request).
REQ-021 pass SHALL be 0 in IDLE, PENDING, LOCKOUT; lockout SHALL be 1 only in LOCKOUT.
REQ-022 Latency: btn_raw=1 first sampled at edge 0 and held clean SHALL give btn_db=1 after edge DEB_CYCLES+1, PENDING after edge DEB_CYCLES+2, pass=1 after edge DEB_CYCLES+3 (light_g=0).
REQ-023 light_g change while in ISSUE or LOCKOUT SHALL NOT alter the sequence.

Reset
REQ-024 rst=1 at an edge SHALL set state IDLE, queued=0, synchronizer flops, btn_db, btn_db_prev, db_cnt, lock_cnt, pass_count to 0; pass, req_pending, lockout SHALL be 0 after that edge.
REQ-025 rst mid-ISSUE SHALL drop pass after that edge with no partial-grant count change beyond the already-counted grant; a button held through reset SHALL re-debounce from 0 and then generate one press_evt.

Verification
REQ-026 Defaults, light_g=0, btn_raw 0->1 clean at edge 0 -> pass=1 for the cycle after edge 19 only, pass_count=1, lockout=1 for 2048 cycles, then IDLE.
REQ-027 btn_raw pulses high for 10 cycles, low 3, repeated 5 times (DEB_CYCLES=16) -> no press_evt, pass never 1, req_pending 0.
REQ-028 Press while light_g=1 -> PENDING one cycle, then IDLE; pass never 1, pass_count stays 0.
REQ-029 Grant, then 3 clean presses during LOCKOUT -> req_pending=1 from first, exactly one second grant right after LOCKOUT ends (PENDING 1 cycle, pass next), pass_count=2.
REQ-030 PASS_CYCLES=3, assert rst at second pass cycle -> pass=0 after reset edge, all outputs 0, pass_count=0.
REQ-031 256 grants with LOCKOUT_CYCLES=1 -> pass_count wraps to 0; each grant pass width exactly PASS_CYCLES.
